// File: rtl/chal_index_sampler_if.sv
// Hash-engine handshake bundle for chal_index_sampler.
// Ports:
//   hash_req    - sampler requests a digest (level, held until hash_ack)
//   hash_rehash - valid with hash_req: 0 = initial digest, 1 = hash of previous digest
//   hash_ack    - engine presents a valid digest (sampled only while hash_req=1)
//   hash_digest - digest data, captured on hash_ack
// Modports: master = sampler side, slave = hash engine side.
interface chal_index_sampler_if #(
    parameter int unsigned DIGEST_W = 256
);
    logic                hash_req;
    logic                hash_rehash;
    logic                hash_ack;
    logic [DIGEST_W-1:0] hash_digest;

    modport master (output hash_req, output hash_rehash, input hash_ack, input hash_digest);
    modport slave  (input hash_req, input hash_rehash, output hash_ack, output hash_digest);
endinterface

// File: rtl/chal_index_sampler.sv
// Challenge index sampler: rejection-samples TAU distinct circuit indices (Lc)
// and TAU party indices (Lp) from MSB-first CHUNK_W-bit chunks of hash digests,
// requesting rehashes when a digest's chunks run out.
// Optional feature macro: CHAL_UNIQUE_LP_EN (Lp also rejects duplicates).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - one-cycle pulse, begins a run when idle
//   busy        - run in progress
//   done, fail  - one-cycle completion pulse; fail=1 when MAX_DIGESTS exhausted
//   hash        - hash engine handshake (chal_index_sampler_if.master)
//   lc, lp      - sampled lists, entry 0 in the MSBs, held until next done
module chal_index_sampler #(
    parameter int unsigned DIGEST_W    = 256,
    parameter int unsigned CHUNK_W     = 5,
    parameter int unsigned TAU         = 4,
    parameter int unsigned NUM_CIRC    = 8,
    parameter int unsigned NUM_PARTY   = 16,
    parameter int unsigned MAX_DIGESTS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    chal_index_sampler_if.master     hash,
    output logic [TAU*CHUNK_W-1:0]   lc,
    output logic [TAU*CHUNK_W-1:0]   lp
);
    localparam int unsigned NCH   = DIGEST_W / CHUNK_W;
    localparam int unsigned CNT_W = $clog2(TAU + 1);
    localparam int unsigned CHK_W = $clog2(NCH + 1);
    localparam int unsigned DIG_W = $clog2(MAX_DIGESTS + 1);
    localparam int unsigned LIM_W = CHUNK_W + 1;
    localparam int unsigned LST_W = TAU * CHUNK_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [LIM_W-1:0] CIRC_LIM  = LIM_W'(NUM_CIRC);
    localparam logic [LIM_W-1:0] PARTY_LIM = LIM_W'(NUM_PARTY);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TAU - 1);
    localparam logic [CHK_W-1:0] CHK_LAST  = CHK_W'(NCH - 1);
    localparam logic [DIG_W-1:0] DIG_MAX   = DIG_W'(MAX_DIGESTS);

    logic [1:0]          state, state_n;
    logic                phase, phase_n;      // 0 = filling Lc, 1 = filling Lp
    logic [CNT_W-1:0]    cnt, cnt_n;          // entries accepted in current list
    logic [CHK_W-1:0]    chunk, chunk_n;      // chunks consumed from current digest
    logic [DIG_W-1:0]    digs, digs_n;        // digests requested this run
    logic [DIGEST_W-1:0] shreg, shreg_n;
    logic [CHUNK_W-1:0]  lc_list [TAU];
    logic [CHUNK_W-1:0]  lc_list_n [TAU];
    logic [CHUNK_W-1:0]  lp_list [TAU];
    logic [CHUNK_W-1:0]  lp_list_n [TAU];
    logic [LST_W-1:0]    lc_pack_n, lp_pack_n;
    logic [CHUNK_W-1:0]  cand;
    logic                dup_c, dup_p, accept, list_done, rehash_n, fail_n;

    // Next-state, datapath and output decode
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        cnt_n     = cnt;
        chunk_n   = chunk;
        digs_n    = digs;
        shreg_n   = shreg;
        lc_list_n = lc_list;
        lp_list_n = lp_list;
        rehash_n  = hash.hash_rehash;
        fail_n    = 1'b0;
        cand      = shreg[DIGEST_W-1 -: CHUNK_W];
        dup_c     = 1'b0;
        dup_p     = 1'b0;
        lc_pack_n = '0;
        lp_pack_n = '0;

        // Only filled slots take part in the duplicate check
        for (int i = 0; i < TAU; i++) begin
            if (CNT_W'(i) < cnt && lc_list[i] == cand) dup_c = 1'b1;
            if (CNT_W'(i) < cnt && lp_list[i] == cand) dup_p = 1'b1;
        end

        if (!phase) begin
            accept = ({1'b0, cand} < CIRC_LIM) && !dup_c;
        end else begin
`ifdef CHAL_UNIQUE_LP_EN
            accept = ({1'b0, cand} < PARTY_LIM) && !dup_p;
`else
            accept = ({1'b0, cand} < PARTY_LIM);
`endif
        end
        list_done = accept && (cnt == CNT_LAST);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_REQ;
                    rehash_n = 1'b0;
                    phase_n  = 1'b0;
                    cnt_n    = '0;
                    digs_n   = DIG_W'(1);
                    for (int i = 0; i < TAU; i++) begin
                        lc_list_n[i] = '0;
                        lp_list_n[i] = '0;
                    end
                end
            end
            S_REQ: begin
                if (hash.hash_ack) begin
                    shreg_n = hash.hash_digest;
                    chunk_n = '0;
                    state_n = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                shreg_n = shreg << CHUNK_W;
                chunk_n = chunk + 1'b1;
                if (accept) begin
                    for (int i = 0; i < TAU; i++) begin
                        if (CNT_W'(i) == cnt) begin
                            if (!phase) lc_list_n[i] = cand;
                            else        lp_list_n[i] = cand;
                        end
                    end
                    cnt_n = cnt + 1'b1;
                end
                if (list_done && phase) begin
                    state_n = S_DONE;
                end else begin
                    // Lc complete: Lp continues on the remaining chunks
                    if (list_done) begin
                        phase_n = 1'b1;
                        cnt_n   = '0;
                    end
                    if (chunk == CHK_LAST) begin
                        if (digs == DIG_MAX) begin
                            state_n = S_DONE;
                            fail_n  = 1'b1;
                        end else begin
                            state_n  = S_REQ;
                            rehash_n = 1'b1;
                            digs_n   = digs + 1'b1;
                        end
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        for (int i = 0; i < TAU; i++) begin
            lc_pack_n[(TAU-1-i)*CHUNK_W +: CHUNK_W] = lc_list_n[i];
            lp_pack_n[(TAU-1-i)*CHUNK_W +: CHUNK_W] = lp_list_n[i];
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            phase            <= 1'b0;
            cnt              <= '0;
            chunk            <= '0;
            digs             <= '0;
            shreg            <= '0;
            for (int i = 0; i < TAU; i++) begin
                lc_list[i] <= '0;
                lp_list[i] <= '0;
            end
            busy             <= 1'b0;
            done             <= 1'b0;
            fail             <= 1'b0;
            hash.hash_req    <= 1'b0;
            hash.hash_rehash <= 1'b0;
            lc               <= '0;
            lp               <= '0;
        end else begin
            state            <= state_n;
            phase            <= phase_n;
            cnt              <= cnt_n;
            chunk            <= chunk_n;
            digs             <= digs_n;
            shreg            <= shreg_n;
            lc_list          <= lc_list_n;
            lp_list          <= lp_list_n;
            busy             <= (state_n == S_REQ) || (state_n == S_SAMPLE);
            done             <= (state_n == S_DONE);
            fail             <= (state_n == S_DONE) && fail_n;
            hash.hash_req    <= (state_n == S_REQ);
            hash.hash_rehash <= (state_n == S_REQ) && rehash_n;
            if (state_n == S_DONE) begin
                lc <= lc_pack_n;
                lp <= lp_pack_n;
            end
        end
    end
endmodule

// File: tb/tb_chal_index_sampler.sv
// Directed bench for chal_index_sampler with a list-level reference model.
module tb_chal_index_sampler;
    localparam int unsigned DIGEST_W    = 256;
    localparam int unsigned CHUNK_W     = 5;
    localparam int unsigned TAU         = 4;
    localparam int unsigned NUM_CIRC    = 8;
    localparam int unsigned NUM_PARTY   = 16;
    localparam int unsigned MAX_DIGESTS = 16;
    localparam int unsigned NCH         = DIGEST_W / CHUNK_W;
    localparam int unsigned LW          = TAU * CHUNK_W;

    localparam int T1_D0[10] = '{3, 3, 9, 1, 7, 0, 5, 5, 20, 15};
`ifdef CHAL_UNIQUE_LP_EN
    localparam logic [LW-1:0] T1_LP = 20'h2BC49;   // 5,15,2,9
    localparam int            T1_CONS1 = 2;
`else
    localparam logic [LW-1:0] T1_LP = 20'h295E2;   // 5,5,15,2
    localparam int            T1_CONS1 = 1;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy, done, fail;
    logic [LW-1:0] lc, lp;

    chal_index_sampler_if #(.DIGEST_W(DIGEST_W)) hif ();

    chal_index_sampler #(
        .DIGEST_W(DIGEST_W), .CHUNK_W(CHUNK_W), .TAU(TAU),
        .NUM_CIRC(NUM_CIRC), .NUM_PARTY(NUM_PARTY), .MAX_DIGESTS(MAX_DIGESTS)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .fail(fail),
        .hash(hif), .lc(lc), .lp(lp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Digest source shared by the hash engine and the model
    logic [DIGEST_W-1:0] dq[$];

    function automatic logic [DIGEST_W-1:0] pick(input int i);
        return dq[(i < dq.size()) ? i : dq.size() - 1];
    endfunction

    function automatic logic [DIGEST_W-1:0] put(input logic [DIGEST_W-1:0] d, input int idx, input int v);
        logic [DIGEST_W-1:0] r;
        r = d;
        r[DIGEST_W-1-idx*CHUNK_W -: CHUNK_W] = CHUNK_W'(v);
        return r;
    endfunction

    // Reference model: walk the digests chunk by chunk applying the list rules
    int            exp_cons[MAX_DIGESTS];
    int            exp_nd;
    logic          exp_fail;
    logic [LW-1:0] exp_lc, exp_lp;

    task automatic model_run();
        int  lcl[TAU];
        int  lpl[TAU];
        int  ph, n, v;
        bit  fin, acc;
        logic [DIGEST_W-1:0] dg;
        for (int i = 0; i < TAU; i++) begin lcl[i] = 0; lpl[i] = 0; end
        for (int i = 0; i < MAX_DIGESTS; i++) exp_cons[i] = 0;
        ph = 0; n = 0; fin = 0; exp_nd = 0;
        for (int d = 0; d < MAX_DIGESTS && !fin; d++) begin
            dg = pick(d);
            exp_nd = d + 1;
            for (int c = 0; c < NCH && !fin; c++) begin
                v = int'(dg[DIGEST_W-1-c*CHUNK_W -: CHUNK_W]);
                exp_cons[d] = c + 1;
                if (ph == 0) begin
                    acc = (v < NUM_CIRC);
                    for (int k = 0; k < n; k++) if (lcl[k] == v) acc = 0;
                    if (acc) begin
                        lcl[n] = v; n++;
                        if (n == TAU) begin ph = 1; n = 0; end
                    end
                end else begin
                    acc = (v < NUM_PARTY);
`ifdef CHAL_UNIQUE_LP_EN
                    for (int k = 0; k < n; k++) if (lpl[k] == v) acc = 0;
`endif
                    if (acc) begin
                        lpl[n] = v; n++;
                        if (n == TAU) fin = 1;
                    end
                end
            end
        end
        exp_fail = !fin;
        exp_lc = '0;
        exp_lp = '0;
        for (int i = 0; i < TAU; i++) begin
            exp_lc = (exp_lc << CHUNK_W) | LW'(lcl[i]);
            exp_lp = (exp_lp << CHUNK_W) | LW'(lpl[i]);
        end
    endtask

    // Hash engine: acks hash_req after ack_dly cycles; man_ack forces one ack
    int ack_dly = 0;
    int eng_wait = 0;
    int nack = 0;
    bit eng_en = 0;
    bit man_ack = 0;

    initial begin
        hif.hash_ack    = 1'b0;
        hif.hash_digest = '0;
        forever begin
            @(posedge clk); #1;
            hif.hash_ack = 1'b0;
            if (man_ack) begin
                hif.hash_ack    = 1'b1;
                hif.hash_digest = '1;
                man_ack         = 0;
            end else if (eng_en && hif.hash_req) begin
                if (eng_wait >= ack_dly) begin
                    hif.hash_ack    = 1'b1;
                    hif.hash_digest = pick(nack);
                    nack++;
                    eng_wait = 0;
                end else begin
                    eng_wait++;
                end
            end else begin
                eng_wait = 0;
            end
        end
    end

    // Compare process: every cycle while a run is monitored
    bit            mon_en = 0;
    bit            ack_seen = 0;
    bit            prev_req = 0;
    int            gap = 0;
    int            nack_mon = 0;
    int            req_cnt = 0;
    int            done_cnt = 0;
    logic [LW-1:0] prev_lc = '0, prev_lp = '0, got_lc = '0, got_lp = '0;
    logic          got_fail = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                done_cnt++;
                got_lc = lc; got_lp = lp; got_fail = fail;
                check("done_lc", 64'(lc), 64'(exp_lc));
                check("done_lp", 64'(lp), 64'(exp_lp));
                check("done_fail", 64'(fail), 64'(exp_fail));
                check("done_busy", 64'(busy), 64'd0);
                if (ack_seen && nack_mon >= 1 && nack_mon <= MAX_DIGESTS)
                    check("done_gap", 64'(gap), 64'(exp_cons[nack_mon-1]));
                ack_seen = 0;
            end else begin
                check("hold_lc", 64'(lc), 64'(prev_lc));
                check("hold_lp", 64'(lp), 64'(prev_lp));
                check("fail_wo_done", 64'(fail), 64'd0);
            end
            if (hif.hash_req) begin
                check("req_busy", 64'(busy), 64'd1);
                check("rehash", 64'(hif.hash_rehash), 64'(req_cnt > 0 || prev_req ? (req_cnt > 1 || (!prev_req && req_cnt > 0)) : 0));
            end
            if (hif.hash_req && !prev_req) begin
                req_cnt++;
                if (ack_seen && nack_mon >= 1 && nack_mon <= MAX_DIGESTS)
                    check("req_gap", 64'(gap), 64'(exp_cons[nack_mon-1]));
                ack_seen = 0;
            end
            if (ack_seen) gap++;
            if (hif.hash_req && hif.hash_ack) begin
                ack_seen = 1; gap = 0; nack_mon++;
            end
            prev_req = hif.hash_req;
            prev_lc = lc;
            prev_lp = lp;
        end
    end

    task automatic run(input string nm, input int dly, input int extra_start);
        int cyc;
        model_run();
        done_cnt = 0; req_cnt = 0; ack_seen = 0; nack_mon = 0; prev_req = 0;
        prev_lc = lc; prev_lp = lp;
        ack_dly = dly; nack = 0; eng_en = 1; mon_en = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({nm, "_busy_after_start"}, 64'(busy), 64'd1);
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == extra_start);
        end
        start = 1'b0;
        if (cyc >= 3000) check({nm, "_timeout"}, 64'd0, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        check({nm, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({nm, "_acks"}, 64'(nack), 64'(exp_nd));
        check({nm, "_req_idle"}, 64'(hif.hash_req), 64'd0);
        check({nm, "_busy_idle"}, 64'(busy), 64'd0);
        mon_en = 0; eng_en = 0;
    endtask

    task automatic load_t1();
        logic [DIGEST_W-1:0] d;
        dq.delete();
        d = '1;
        for (int i = 0; i < 10; i++) d = put(d, i, T1_D0[i]);
        dq.push_back(d);
        d = '1;
        d = put(d, 0, 2);
        d = put(d, 1, 9);
        dq.push_back(d);
    endtask

    initial begin
        logic [DIGEST_W-1:0] d;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_fail", 64'(fail), 64'd0);
        check("rst_req", 64'(hif.hash_req), 64'd0);
        check("rst_rehash", 64'(hif.hash_rehash), 64'd0);
        check("rst_lc", 64'(lc), 64'd0);
        check("rst_lp", 64'(lp), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic run: Lc from digest 0, Lp finished by the rehash
        load_t1();
        run("t1", 0, 0);
        check("t1_model_lc", 64'(exp_lc), 64'h184E0);
        check("t1_model_lp", 64'(exp_lp), 64'(T1_LP));
        check("t1_model_cons1", 64'(exp_cons[1]), 64'(T1_CONS1));
        check("t1_lc", 64'(got_lc), 64'h184E0);
        check("t1_lp", 64'(got_lp), 64'(T1_LP));
        check("t1_fail", 64'(got_fail), 64'd0);
        check("t1_reqs", 64'(req_cnt), 64'd2);

        // Exhaustion: every chunk is 31
        dq.delete();
        dq.push_back('1);
        run("ones", 1, 0);
        check("ones_fail", 64'(got_fail), 64'd1);
        check("ones_lc", 64'(got_lc), 64'd0);
        check("ones_lp", 64'(got_lp), 64'd0);
        check("ones_reqs", 64'(req_cnt), 64'(MAX_DIGESTS));

        // Lc completes on the last chunk, Lp from the rehash
        dq.delete();
        d = '1;
        d = put(d, 47, 0); d = put(d, 48, 1); d = put(d, 49, 2); d = put(d, 50, 3);
        dq.push_back(d);
        d = '1;
        d = put(d, 0, 4); d = put(d, 1, 6); d = put(d, 2, 8); d = put(d, 3, 10);
        dq.push_back(d);
        run("last", 2, 0);
        check("last_model_cons0", 64'(exp_cons[0]), 64'd51);
        check("last_lc", 64'(got_lc), 64'h00443);
        check("last_lp", 64'(got_lp), 64'h2190A);
        check("last_reqs", 64'(req_cnt), 64'd2);

        // Reset while waiting for the digest, then a late ack
        load_t1();
        ack_dly = 1000; eng_en = 1; nack = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        begin
            int w;
            w = 0;
            while (!hif.hash_req && w < 20) begin @(posedge clk); #1; w++; end
            check("rr_req_seen", 64'(hif.hash_req), 64'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        man_ack = 1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rr_req_drop", 64'(hif.hash_req), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("rr_busy", 64'(busy), 64'd0);
        check("rr_req", 64'(hif.hash_req), 64'd0);
        check("rr_done", 64'(done), 64'd0);
        check("rr_lc", 64'(lc), 64'd0);
        check("rr_lp", 64'(lp), 64'd0);
        eng_en = 0;
        run("rr_again", 0, 0);
        check("rr_again_lc", 64'(got_lc), 64'h184E0);

        // start pulse mid-SAMPLE is ignored
        run("midstart", 0, 6);
        check("mid_lp", 64'(got_lp), 64'(T1_LP));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
